// File: rtl/mem_bank_sched.sv
`default_nettype none
// ============================================================================
// Module   : mem_bank_sched
// Purpose  : Four-bank 16-bit memory scheduler. Each bank stays occupied for
//            BANK_LAT cycles after an accepted access. Reads return through
//            an RD_LAT-deep pipeline. Requests to a busy bank stall, and
//            malformed requests raise err.
// Revision : 1.0  initial release
// ============================================================================
module mem_bank_sched #(
    parameter int BANK_LAT   = 4,
    parameter int RD_LAT     = 2,
    parameter int BANK_WORDS = 8192
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    input  logic        wr,
    input  logic        rd,
    output logic [15:0] data_out,
    output logic        rd_valid,
    output logic [3:0]  busy,
    output logic        stall,
    output logic        err
);

    // Counter only needs to hold BANK_LAT-1. Keep at least one bit so a
    // BANK_LAT of 1 still elaborates.
    localparam int               CNT_W    = (BANK_LAT > 1) ? $clog2(BANK_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BANK_LAT - 1);

    // Stop elaboration when the read pipeline cannot fit inside a bank slot.
    if (RD_LAT < 1 || RD_LAT > BANK_LAT) begin : g_bad_rd_lat
        $error("mem_bank_sched: RD_LAT must lie in 1..BANK_LAT");
    end

    logic [1:0]       bank_sel;
    logic [12:0]      word_idx;
    logic             req;
    logic             accept;
    logic             rd_accept;
    logic             wr_accept;
    logic [CNT_W-1:0] bank_cnt [4];
    logic [15:0]      mem      [4][BANK_WORDS];
    logic [RD_LAT-1:0] pipe_vld;
    logic [15:0]      pipe_dat [RD_LAT];

    assign bank_sel = addr[2:1];
    assign word_idx = addr[15:3];
    assign req      = rd | wr;

    // A simultaneous read/write or an odd byte address is rejected outright.
    // That rejection takes priority over stall.
    assign err       = (rd & wr) | (req & addr[0]);
    assign stall     = req & ~err & busy[bank_sel];
    assign accept    = req & ~err & ~stall;
    assign rd_accept = accept & rd;
    assign wr_accept = accept & wr;

    // busy is derived directly from the counters, so reset clears it at once.
    for (genvar b = 0; b < 4; b++) begin : g_busy
        assign busy[b] = |bank_cnt[b];
    end

    // Per-bank occupancy counters: load on accept, otherwise count down to 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                bank_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (accept && (bank_sel == 2'(i))) begin
                    bank_cnt[i] <= CNT_LOAD;
                end else if (bank_cnt[i] != '0) begin
                    bank_cnt[i] <= bank_cnt[i] - 1'b1;
                end
            end
        end
    end

    // Storage array. It has no reset, and its contents survive rst.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[bank_sel][word_idx] <= data_in;
        end
    end

    // Read return pipeline. The word is captured at the accept edge, so later
    // writes cannot disturb a read that is already in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_vld <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_dat[i] <= '0;
            end
        end else begin
            pipe_vld[0] <= rd_accept;
            pipe_dat[0] <= rd_accept ? mem[bank_sel][word_idx] : 16'h0000;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_dat[i] <= pipe_dat[i-1];
            end
        end
    end

    assign rd_valid = pipe_vld[RD_LAT-1];
    assign data_out = rd_valid ? pipe_dat[RD_LAT-1] : 16'h0000;

endmodule
`default_nettype wire
